// File: rtl/dcache_ecc_scrubber_pkg.sv
// rtl/dcache_ecc_scrubber_pkg.sv - dcache geometry, line/byte-enable types, ECC error and scrubber FSM types
package dcache_ecc_scrubber_pkg;

   localparam int unsigned DCACHE_SET_ASSOC   = 8;
   localparam int unsigned DCACHE_INDEX_WIDTH = 12;
   localparam int unsigned DCACHE_BYTE_OFFSET = 4;
   localparam int unsigned DCACHE_TAG_WIDTH   = 8;
   localparam int unsigned DCACHE_LINE_WIDTH  = 128;

   typedef struct packed {
      logic [DCACHE_TAG_WIDTH-1:0]  tag;
      logic [DCACHE_LINE_WIDTH-1:0] data;
      logic                         valid;
      logic                         dirty;
   } cache_line_t;

   typedef struct packed {
      logic [DCACHE_TAG_WIDTH/8-1:0]  tag;
      logic [DCACHE_LINE_WIDTH/8-1:0] data;
      logic [DCACHE_SET_ASSOC-1:0]    vldrty;
   } cl_be_t;

   typedef struct packed {
      logic uncorr;
      logic corr;
   } ecc_err_t;

   typedef enum logic [1:0] {
      SCRUB_IDLE = 2'd0,
      SCRUB_RD   = 2'd1,
      SCRUB_WR   = 2'd2
   } scrub_state_e;

endpackage

// File: rtl/dcache_ecc_scrubber_fifo.sv
// rtl/dcache_ecc_scrubber_fifo.sv - pending set-index queue (power-of-two depth, push ignored when full)
module dcache_ecc_scrubber_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/dcache_ecc_scrubber.sv
// rtl/dcache_ecc_scrubber.sv - dcache ECC error capture, counters, and read-correct-write set scrubber
module dcache_ecc_scrubber
   import dcache_ecc_scrubber_pkg::*;
#(
   parameter int unsigned NUM_WAYS     = DCACHE_SET_ASSOC,
   parameter int unsigned INDEX_WIDTH  = DCACHE_INDEX_WIDTH,
   parameter int unsigned BYTE_OFFSET  = DCACHE_BYTE_OFFSET,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned CNT_WIDTH    = 16,
   parameter int unsigned SCRUB_PERIOD = 1024
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             enable_i,
   input  logic                             clr_i,
   input  logic [NUM_WAYS-1:0]              ram_req_i,
   input  logic                             ram_we_i,
   input  logic [INDEX_WIDTH-1:0]           ram_addr_i,
   input  ecc_err_t [NUM_WAYS-1:0]          data_err_i,
   input  ecc_err_t [NUM_WAYS-1:0]          tag_err_i,
   input  ecc_err_t                         vd_err_i,
   output logic [NUM_WAYS-1:0]              req_o,
   output logic [INDEX_WIDTH-1:0]           addr_o,
   input  logic                             gnt_i,
   output logic                             we_o,
   output cl_be_t                           be_o,
   output cache_line_t [NUM_WAYS-1:0]       wdata_o,
   input  cache_line_t [NUM_WAYS-1:0]       rdata_i,
   output logic [CNT_WIDTH-1:0]             corr_cnt_o,
   output logic [CNT_WIDTH-1:0]             uncorr_cnt_o,
   output logic [INDEX_WIDTH-1:0]           uncorr_addr_o,
   output logic                             overflow_o,
   output logic                             irq_o,
   output logic                             busy_o
);
   localparam int unsigned SET_W = INDEX_WIDTH - BYTE_OFFSET;
   localparam int unsigned TMR_W = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((SCRUB_PERIOD == 0) ? 0 : SCRUB_PERIOD - 1);

   scrub_state_e     state_q, state_d;
   logic [SET_W-1:0] set_q, set_d;
   logic             bg_q, bg_d;
   logic             rd_q, own_q;
   logic [INDEX_WIDTH-1:0] addr_q;
   logic [SET_W-1:0] last_idx_q, ptr_q, fifo_data;
   logic [TMR_W-1:0] tmr_q;
   logic             pend_q, tick;
   logic             any_corr, any_uncorr, err_valid, push_req, pop;
   logic             fifo_full, fifo_empty, scrub_done;

   always_comb begin
      any_corr   = vd_err_i.corr;
      any_uncorr = vd_err_i.uncorr;
      for (int w = 0; w < int'(NUM_WAYS); w++) begin
         any_corr   = any_corr   | data_err_i[w].corr   | tag_err_i[w].corr;
         any_uncorr = any_uncorr | data_err_i[w].uncorr | tag_err_i[w].uncorr;
      end
   end

   assign err_valid = rd_q && (any_corr || any_uncorr);
   // The newest push is always the last entry in the queue while it is non-empty.
   assign push_req  = err_valid && any_corr && !any_uncorr && !own_q &&
                      !(!fifo_empty && (last_idx_q == addr_q[INDEX_WIDTH-1:BYTE_OFFSET]));
   assign scrub_done = (state_q == SCRUB_WR) && (any_uncorr || gnt_i);
   assign tick       = (SCRUB_PERIOD != 0) && enable_i && (tmr_q == TMR_LAST);
   assign busy_o     = (state_q != SCRUB_IDLE) || !fifo_empty;

   dcache_ecc_scrubber_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SET_W)
   ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push_req),
      .data_i  (addr_q[INDEX_WIDTH-1:BYTE_OFFSET]),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q          <= 1'b0;
         own_q         <= 1'b0;
         addr_q        <= '0;
         last_idx_q    <= '0;
         corr_cnt_o    <= '0;
         uncorr_cnt_o  <= '0;
         uncorr_addr_o <= '0;
         overflow_o    <= 1'b0;
         irq_o         <= 1'b0;
      end else begin
         rd_q   <= (|ram_req_i) && !ram_we_i;
         own_q  <= (state_q == SCRUB_RD) && gnt_i;
         addr_q <= ram_addr_i;
         if (push_req && !fifo_full) last_idx_q <= addr_q[INDEX_WIDTH-1:BYTE_OFFSET];
         if (clr_i) begin
            corr_cnt_o   <= '0;
            uncorr_cnt_o <= '0;
            overflow_o   <= 1'b0;
            irq_o        <= 1'b0;
         end else begin
            if (err_valid && any_corr && (corr_cnt_o != '1))
               corr_cnt_o <= corr_cnt_o + CNT_WIDTH'(1);
            if (err_valid && any_uncorr && (uncorr_cnt_o != '1))
               uncorr_cnt_o <= uncorr_cnt_o + CNT_WIDTH'(1);
            if (err_valid && any_uncorr) begin
               irq_o         <= 1'b1;
               uncorr_addr_o <= addr_q;
            end
            if (push_req && fifo_full) overflow_o <= 1'b1;
         end
      end
   end

   // An aborted background scrub still advances, so a hard fault cannot pin the walk to one set.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmr_q  <= '0;
         pend_q <= 1'b0;
         ptr_q  <= '0;
      end else begin
         if ((SCRUB_PERIOD != 0) && enable_i)
            tmr_q <= tick ? '0 : tmr_q + TMR_W'(1);
         if (scrub_done && bg_q) begin
            pend_q <= 1'b0;
            ptr_q  <= ptr_q + SET_W'(1);
         end
         if (tick) pend_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= SCRUB_IDLE;
         set_q   <= '0;
         bg_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         set_q   <= set_d;
         bg_q    <= bg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      set_d   = set_q;
      bg_d    = bg_q;
      pop     = 1'b0;
      req_o   = '0;
      we_o    = 1'b0;
      addr_o  = '0;
      be_o    = '0;
      wdata_o = '0;
      unique case (state_q)
         SCRUB_IDLE: begin
            if (enable_i && !fifo_empty) begin
               pop     = 1'b1;
               set_d   = fifo_data;
               bg_d    = 1'b0;
               state_d = SCRUB_RD;
            end else if (enable_i && pend_q) begin
               set_d   = ptr_q;
               bg_d    = 1'b1;
               state_d = SCRUB_RD;
            end
         end
         SCRUB_RD: begin
            req_o  = '1;
            addr_o = {set_q, {BYTE_OFFSET{1'b0}}};
            if (gnt_i) state_d = SCRUB_WR;
         end
         SCRUB_WR: begin
            if (any_uncorr) begin
               state_d = SCRUB_IDLE;
            end else begin
               req_o   = '1;
               we_o    = 1'b1;
               be_o    = '1;
               addr_o  = {set_q, {BYTE_OFFSET{1'b0}}};
               wdata_o = rdata_i;
               state_d = gnt_i ? SCRUB_IDLE : SCRUB_RD;
            end
         end
         default: state_d = SCRUB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcache_ecc_scrubber.sv
// tb/tb_dcache_ecc_scrubber.sv - self-checking bench for dcache_ecc_scrubber
module tb_dcache_ecc_scrubber;
   import dcache_ecc_scrubber_pkg::*;

   localparam int NW = 8, IW = 12, BO = 4, SW = IW - BO, NSETS = 1 << SW;

   typedef struct {
      logic          we;
      logic [IW-1:0] addr;
      logic          req_ok;
      logic          data_ok;
      int            cyc;
   } txn_t;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_fail = 0;
   int m_corr = 0, m_uncorr = 0;
   logic m_irq = 1'b0, m_ovf = 1'b0;
   logic [IW-1:0] m_uaddr = '0;
   logic [SW-1:0] m_q[$];
   txn_t log_q[$], log_bg[$];

   function automatic cache_line_t line_of(input logic [SW-1:0] s, input int w);
      cache_line_t l;
      l.tag   = s ^ 8'(w * 37);
      l.data  = {8{s, 8'(w)}};
      l.valid = s[0] ^ w[0];
      l.dirty = s[1];
      return l;
   endfunction

   // main DUT (no background scrubbing)
   logic enable = 1'b0, clr = 1'b0, gnt = 1'b1;
   logic [NW-1:0] tb_req = '0;
   logic tb_we = 1'b0;
   logic [IW-1:0] tb_addr = '0;
   ecc_err_t [NW-1:0] data_err = '0, tag_err = '0;
   ecc_err_t vd_err = '0;
   logic [NW-1:0] req, ram_req;
   logic [IW-1:0] addr, ram_addr, uncorr_addr;
   logic we, ram_we, overflow, irq, busy;
   cl_be_t be;
   cache_line_t [NW-1:0] wdata, rdata;
   logic [15:0] corr_cnt, uncorr_cnt;
   logic [SW-1:0] rd_set_q;

   assign ram_req  = (|req && gnt) ? req  : tb_req;
   assign ram_we   = (|req && gnt) ? we   : tb_we;
   assign ram_addr = (|req && gnt) ? addr : tb_addr;
   always @(posedge clk) rd_set_q <= ram_addr[IW-1:BO];
   always_comb for (int w = 0; w < NW; w++) rdata[w] = line_of(rd_set_q, w);

   dcache_ecc_scrubber #(.NUM_WAYS(NW), .INDEX_WIDTH(IW), .BYTE_OFFSET(BO), .FIFO_DEPTH(4),
      .CNT_WIDTH(16), .SCRUB_PERIOD(0)) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clr_i(clr),
      .ram_req_i(ram_req), .ram_we_i(ram_we), .ram_addr_i(ram_addr),
      .data_err_i(data_err), .tag_err_i(tag_err), .vd_err_i(vd_err),
      .req_o(req), .addr_o(addr), .gnt_i(gnt), .we_o(we), .be_o(be),
      .wdata_o(wdata), .rdata_i(rdata), .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt),
      .uncorr_addr_o(uncorr_addr), .overflow_o(overflow), .irq_o(irq), .busy_o(busy));

   // background-scrub DUT, arbiter always grants, no errors
   logic enable_bg = 1'b0, clr_bg = 1'b0, gnt_bg = 1'b1;
   ecc_err_t [NW-1:0] zero_err = '0;
   ecc_err_t zero_vd = '0;
   logic [NW-1:0] req_b;
   logic [IW-1:0] addr_b, uaddr_b;
   logic we_b, ovf_b, irq_b, busy_b;
   cl_be_t be_b;
   cache_line_t [NW-1:0] wdata_b, rdata_b;
   logic [15:0] ccnt_b, ucnt_b;
   logic [SW-1:0] rd_set_b_q;

   always @(posedge clk) rd_set_b_q <= addr_b[IW-1:BO];
   always_comb for (int w = 0; w < NW; w++) rdata_b[w] = line_of(rd_set_b_q, w);

   dcache_ecc_scrubber #(.NUM_WAYS(NW), .INDEX_WIDTH(IW), .BYTE_OFFSET(BO), .FIFO_DEPTH(4),
      .CNT_WIDTH(16), .SCRUB_PERIOD(8)) dut_bg (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable_bg), .clr_i(clr_bg),
      .ram_req_i(req_b), .ram_we_i(we_b), .ram_addr_i(addr_b),
      .data_err_i(zero_err), .tag_err_i(zero_err), .vd_err_i(zero_vd),
      .req_o(req_b), .addr_o(addr_b), .gnt_i(gnt_bg), .we_o(we_b), .be_o(be_b),
      .wdata_o(wdata_b), .rdata_i(rdata_b), .corr_cnt_o(ccnt_b), .uncorr_cnt_o(ucnt_b),
      .uncorr_addr_o(uaddr_b), .overflow_o(ovf_b), .irq_o(irq_b), .busy_o(busy_b));

   always @(negedge clk) begin : mon
      txn_t t;
      if (rst_n && |req && gnt) begin
         t.we = we; t.addr = addr; t.req_ok = (req == '1); t.cyc = cyc;
         t.data_ok = !we || (be == '1);
         for (int w = 0; w < NW; w++)
            if (we && wdata[w] !== line_of(addr[IW-1:BO], w)) t.data_ok = 1'b0;
         log_q.push_back(t);
      end
      if (rst_n && |req_b && we_b) begin
         t.we = we_b; t.addr = addr_b; t.req_ok = (req_b == '1); t.cyc = cyc;
         t.data_ok = (be_b == '1);
         for (int w = 0; w < NW; w++)
            if (wdata_b[w] !== line_of(addr_b[IW-1:BO], w)) t.data_ok = 1'b0;
         log_bg.push_back(t);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_corr = 0; m_uncorr = 0; m_irq = 1'b0; m_ovf = 1'b0;
   endtask

   // Host read followed by the error response one cycle later; updates the reference model.
   task automatic host_read(input logic [IW-1:0] a, input ecc_err_t [NW-1:0] de,
                            input ecc_err_t [NW-1:0] te, input ecc_err_t ve);
      logic c, u;
      logic [SW-1:0] s;
      tb_req = NW'($urandom_range(1, 255)); tb_we = 1'b0; tb_addr = a;
      tick();
      tb_req = '0; data_err = de; tag_err = te; vd_err = ve;
      tick();
      data_err = '0; tag_err = '0; vd_err = '0;
      c = ve.corr; u = ve.uncorr;
      for (int w = 0; w < NW; w++) begin
         c = c | de[w].corr | te[w].corr;
         u = u | de[w].uncorr | te[w].uncorr;
      end
      if (c && m_corr < 65535) m_corr++;
      if (u && m_uncorr < 65535) m_uncorr++;
      if (u) begin m_irq = 1'b1; m_uaddr = a; end
      s = a[IW-1:BO];
      if (c && !u && !(m_q.size() > 0 && m_q[$] == s)) begin
         if (m_q.size() == 4) m_ovf = 1'b1;
         else m_q.push_back(s);
      end
   endtask

   task automatic wait_idle(output bit ok);
      int i = 0;
      while (busy && i < 200) begin tick(); i++; end
      tick(2);
      ok = !busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(2);
      n_cmp++; if (req !== '0 || we !== 1'b0 || addr !== '0 || be !== '0 || wdata !== '0) begin
         n_fail++; $display("FAIL reset_port: req=%h we=%b addr=%h want all 0", req, we, addr); end
      n_cmp++; if (corr_cnt !== '0 || uncorr_cnt !== '0 || uncorr_addr !== '0) begin
         n_fail++; $display("FAIL reset_cnt: corr=%0d uncorr=%0d uaddr=%h want 0", corr_cnt, uncorr_cnt, uncorr_addr); end
      n_cmp++; if (overflow !== 1'b0 || irq !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags: ovf=%b irq=%b busy=%b want 0", overflow, irq, busy); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_corr();
      ecc_err_t [NW-1:0] de = '0;
      bit ok;
      log_q.delete(); m_q.delete();
      enable = 1'b1;
      de[3].corr = 1'b1;
      host_read(12'h150, de, '0, '0);
      n_cmp++; if (corr_cnt !== 16'(m_corr)) begin
         n_fail++; $display("FAIL corr_cnt: got %0d want %0d", corr_cnt, m_corr); end
      wait_idle(ok);
      n_cmp++; if (!ok || log_q.size() != 2) begin
         n_fail++; $display("FAIL corr_scrub_count: idle=%b txns=%0d want 1/2", ok, log_q.size()); end
      else begin
         n_cmp++; if (log_q[0].we !== 1'b0 || log_q[0].addr !== 12'h150 || !log_q[0].req_ok) begin
            n_fail++; $display("FAIL corr_rd: we=%b addr=%h want 0/150", log_q[0].we, log_q[0].addr); end
         n_cmp++; if (log_q[1].we !== 1'b1 || log_q[1].addr !== 12'h150 || !log_q[1].data_ok
                      || log_q[1].cyc != log_q[0].cyc + 1) begin
            n_fail++; $display("FAIL corr_wr: we=%b addr=%h data_ok=%b gap=%0d want 1/150/1/1",
               log_q[1].we, log_q[1].addr, log_q[1].data_ok, log_q[1].cyc - log_q[0].cyc); end
      end
      m_q.delete();
   endtask

   task automatic test_uncorr_clr();
      ecc_err_t [NW-1:0] te = '0;
      te[$urandom_range(0, NW-1)].uncorr = 1'b1;
      log_q.delete();
      host_read(12'h2A0, '0, te, '0);
      n_cmp++; if (uncorr_cnt !== 16'(m_uncorr) || uncorr_addr !== m_uaddr || irq !== m_irq) begin
         n_fail++; $display("FAIL uncorr: cnt=%0d addr=%h irq=%b want %0d/%h/%b",
            uncorr_cnt, uncorr_addr, irq, m_uncorr, m_uaddr, m_irq); end
      tick(6);
      n_cmp++; if (log_q.size() != 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL uncorr_noscrub: txns=%0d busy=%b want 0/0", log_q.size(), busy); end
      clr = 1'b1; tick(); clr = 1'b0; model_clear();
      n_cmp++; if (corr_cnt !== '0 || uncorr_cnt !== '0 || irq !== 1'b0 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL clr: corr=%0d uncorr=%0d irq=%b ovf=%b want 0", corr_cnt, uncorr_cnt, irq, overflow); end
   endtask

   task automatic test_overflow();
      logic [SW-1:0] base, exp[$];
      ecc_err_t [NW-1:0] de, te;
      bit ok;
      enable = 1'b0; log_q.delete(); m_q.delete();
      base = SW'($urandom);
      for (int i = 0; i < 6; i++) begin
         de = '0; te = '0;
         if ($urandom_range(0, 1)) de[$urandom_range(0, NW-1)].corr = 1'b1;
         else te[$urandom_range(0, NW-1)].corr = 1'b1;
         host_read({base + SW'(i * 37), 4'($urandom)}, de, te, '0);
      end
      n_cmp++; if (overflow !== m_ovf || corr_cnt !== 16'(m_corr) || m_q.size() != 4) begin
         n_fail++; $display("FAIL overflow: ovf=%b cnt=%0d want %b/%0d", overflow, corr_cnt, m_ovf, m_corr); end
      exp = m_q; m_q.delete();
      enable = 1'b1;
      wait_idle(ok);
      n_cmp++; if (!ok || log_q.size() != 8) begin
         n_fail++; $display("FAIL overflow_scrubs: idle=%b txns=%0d want 1/8", ok, log_q.size()); end
      else for (int i = 0; i < 4; i++) begin
         n_cmp++; if (log_q[2*i].we !== 1'b0 || log_q[2*i+1].we !== 1'b1 || log_q[2*i].addr !== {exp[i], 4'h0}
                      || log_q[2*i+1].addr !== {exp[i], 4'h0} || !log_q[2*i+1].data_ok) begin
            n_fail++; $display("FAIL fifo_order[%0d]: rd=%h wr=%h want %h", i, log_q[2*i].addr,
               log_q[2*i+1].addr, {exp[i], 4'h0}); end
      end
      clr = 1'b1; tick(); clr = 1'b0; model_clear();
      n_cmp++; if (overflow !== 1'b0) begin
         n_fail++; $display("FAIL overflow_clr: got %b want 0", overflow); end
   endtask

   task automatic test_same_index();
      logic [SW-1:0] s;
      ecc_err_t [NW-1:0] de;
      ecc_err_t ve;
      bit ok;
      enable = 1'b0; log_q.delete(); m_q.delete();
      s = SW'($urandom);
      for (int i = 0; i < 3; i++) begin
         de = '0; ve = '0;
         if (i == 1) ve.corr = 1'b1; else de[$urandom_range(0, NW-1)].corr = 1'b1;
         host_read({s, 4'($urandom)}, de, '0, ve);
      end
      n_cmp++; if (corr_cnt !== 16'(m_corr) || m_corr != 3) begin
         n_fail++; $display("FAIL same_idx_cnt: got %0d want 3", corr_cnt); end
      enable = 1'b1;
      wait_idle(ok);
      n_cmp++; if (!ok || log_q.size() != 2 || log_q[0].addr !== {s, 4'h0} || m_q.size() != 1) begin
         n_fail++; $display("FAIL same_idx_scrubs: txns=%0d want 2 at %h", log_q.size(), {s, 4'h0}); end
      m_q.delete();
   endtask

   task automatic test_gnt_stall();
      ecc_err_t [NW-1:0] de = '0;
      logic [SW-1:0] s;
      int i = 0;
      bit ok;
      enable = 1'b0; log_q.delete(); m_q.delete();
      s = SW'($urandom);
      de[$urandom_range(0, NW-1)].corr = 1'b1;
      host_read({s, 4'($urandom)}, de, '0, '0);
      enable = 1'b1;
      while (!(|req && we) && i < 20) begin tick(); i++; end
      gnt = 1'b0;
      tick();
      n_cmp++; if (req !== '1 || we !== 1'b0 || addr !== {s, 4'h0}) begin
         n_fail++; $display("FAIL stall_reread: req=%h we=%b addr=%h want ff/0/%h", req, we, addr, {s, 4'h0}); end
      tick(2);
      n_cmp++; if (req !== '1 || we !== 1'b0) begin
         n_fail++; $display("FAIL stall_hold: req=%h we=%b want ff/0", req, we); end
      gnt = 1'b1;
      wait_idle(ok);
      n_cmp++; if (!ok || log_q.size() != 3 || log_q[1].we !== 1'b0 || log_q[2].we !== 1'b1
                   || log_q[2].addr !== {s, 4'h0} || !log_q[2].data_ok) begin
         n_fail++; $display("FAIL stall_seq: txns=%0d want RD,RD,WR at %h", log_q.size(), {s, 4'h0}); end
      m_q.delete();
   endtask

   task automatic test_reset_mid_scrub();
      ecc_err_t [NW-1:0] de = '0;
      int i = 0;
      enable = 1'b0; m_q.delete();
      de[0].corr = 1'b1;
      host_read({SW'($urandom), 4'h0}, de, '0, '0);
      gnt = 1'b0; enable = 1'b1;
      while (req == '0 && i < 20) begin tick(); i++; end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (req !== '0 || busy !== 1'b0 || corr_cnt !== '0) begin
         n_fail++; $display("FAIL reset_mid: req=%h busy=%b cnt=%0d want 0", req, busy, corr_cnt); end
      tick();
      rst_n = 1'b1; gnt = 1'b1; enable = 1'b0;
      model_clear(); m_q.delete();
      tick();
   endtask

   task automatic test_background();
      int i = 0;
      log_bg.delete();
      enable_bg = 1'b1;
      while (log_bg.size() < NSETS + 3 && i < 3000) begin tick(); i++; end
      enable_bg = 1'b0;
      n_cmp++; if (log_bg.size() < NSETS + 3) begin
         n_fail++; $display("FAIL bg_count: got %0d want %0d", log_bg.size(), NSETS + 3); end
      else for (int k = 0; k < NSETS + 3; k++) begin
         n_cmp++; if (log_bg[k].addr !== {SW'(k % NSETS), 4'h0} || !log_bg[k].data_ok || !log_bg[k].req_ok
                      || (k > 0 && log_bg[k].cyc - log_bg[k-1].cyc != 8)) begin
            n_fail++; $display("FAIL bg_scrub[%0d]: addr=%h ok=%b gap=%0d want %h/1/8", k, log_bg[k].addr,
               log_bg[k].data_ok, (k > 0) ? log_bg[k].cyc - log_bg[k-1].cyc : 8, {SW'(k % NSETS), 4'h0}); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_corr();
      test_uncorr_clr();
      test_overflow();
      test_same_index();
      test_gnt_stall();
      test_reset_mid_scrub();
      test_background();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_ecc_scrubber.md
Name: dcache_ecc_scrubber

Overview:
- Parametrised ECC error handler and scrubber for the non-blocking L1 dcache arrays (data, tag and valid/dirty SRAMs).
- Consumes the per-array ECC error outputs, which are currently left unconnected, and queues the faulting set indices.
- Owns a dedicated highest-priority port into the tag-compare arbiter and performs read-correct-write of whole sets.
- Also walks all sets in the background at a programmable period, and keeps saturating error counters plus an interrupt.

Parameters:
- NUM_WAYS, 8 (DCACHE_SET_ASSOC): ways per set.
- INDEX_WIDTH, 12 (DCACHE_INDEX_WIDTH): arbiter address width.
- BYTE_OFFSET, 4 (DCACHE_BYTE_OFFSET): low address bits below the set index.
- FIFO_DEPTH, 4: pending-error queue depth (power of two, ≥2).
- CNT_WIDTH, 16: error counter width.
- SCRUB_PERIOD, 1024: cycles between background scrubs; 0 disables background scrubbing.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  allow new scrubs
- clr_i  in  1  clear counters, overflow and irq
- ram_req_i  in  NUM_WAYS  arbiter→SRAM req, observed
- ram_we_i  in  1  arbiter→SRAM we, observed
- ram_addr_i  in  INDEX_WIDTH  arbiter→SRAM address, observed
- data_err_i  in  NUM_WAYS×2  per-way data SRAM error, {uncorr,corr}, valid 1 cycle after req
- tag_err_i  in  NUM_WAYS×2  per-way tag SRAM error, same format
- vd_err_i  in  2  valid/dirty SRAM error
- req_o  out  NUM_WAYS  arbiter request
- addr_o  out  INDEX_WIDTH  arbiter address
- gnt_i  in  1  arbiter grant (combinational)
- we_o  out  1  write enable
- be_o  out  cl_be_t  byte enables
- wdata_o  out  cache_line_t  write data
- rdata_i  in  NUM_WAYS×cache_line_t  corrected read data, 1 cycle after grant
- corr_cnt_o  out  CNT_WIDTH  correctable error count
- uncorr_cnt_o  out  CNT_WIDTH  uncorrectable error count
- uncorr_addr_o  out  INDEX_WIDTH  index of the last uncorrectable error
- overflow_o  out  1  sticky: a queue entry was dropped
- irq_o  out  1  sticky: an uncorrectable error occurred
- busy_o  out  1  FSM not IDLE or queue non-empty

Behaviour:
- Reset: all outputs 0; FSM IDLE; queue empty; background timer and set pointer 0.
- Error capture:
  - Register (ram_req_i != 0 && !ram_we_i, ram_addr_i) for one cycle.
  - An error is any bit of data_err_i, tag_err_i or vd_err_i in the following cycle, qualified by the registered read.
- Counting: each erroring cycle increments corr_cnt by 1 if any corr bit is set, and uncorr_cnt by 1 if any uncorr bit is set. Both counters saturate at all-ones.
- Uncorrectable error: latch uncorr_addr_o and set irq_o.
- clr_i wins over a simultaneous increment or set.
- Enqueue: push the set index (addr bits [INDEX_WIDTH-1:BYTE_OFFSET]) only for correctable-only errors.
  - Skip the push if the index equals the most recently pushed, still-queued entry.
  - Skip the push if the error came from the scrubber's own read.
  - Queue full: drop the index and set overflow_o. Counters still count.
- FSM:
  - IDLE: if enable_i and queue non-empty, pop and go to RD. Otherwise, if enable_i and a background tick is pending, take the set pointer and go to RD. The queue has priority over the background tick.
  - RD: drive req_o all-ones, we_o=0, addr_o = {set, BYTE_OFFSET zeros}. If gnt_i, go to WR; else stay in RD.
  - WR:
    - Abort condition: any uncorr bit in this cycle's error inputs for the scrub read.
    - On abort: do not write, count it, return to IDLE.
    - Otherwise: drive req_o all-ones, we_o=1 and full be_o, with wdata_o and the valid/dirty fields taken from rdata_i.
    - If gnt_i, go to IDLE.
    - If gnt_i=0 (arbiter priority misconfigured), go back to RD and re-read the set.
  - RD and WR are consecutive cycles at top priority, so no other port can modify the set in between.
- Background scrubbing:
  - The timer counts while enable_i and SCRUB_PERIOD≠0. At SCRUB_PERIOD-1 it wraps and sets a single pending flag; ticks do not accumulate beyond that one flag.
  - A completed background scrub clears the flag and increments the set pointer, wrapping from 2^(INDEX_WIDTH-BYTE_OFFSET)-1 to 0.
- enable_i deasserted mid-scrub: the current RD/WR completes; no new scrub starts; capture and counting continue.
- Reset mid-scrub: abandon immediately; req_o=0 asynchronously.

Decomposition:
- std_cache_pkg: ecc_err_t ({uncorr,corr} struct) and the scrubber FSM enum. cache_line_t, cl_be_t and DCACHE_* constants are reused from the same package.
- Pending-error queue: one instance of the common-cells fifo_v3 (FIFO_DEPTH, width INDEX_WIDTH-BYTE_OFFSET).
- Integrated as arbiter port 0 of a 5-port tag compare.

Test Plan:
- Correctable data error on way 3, read at index 0x150: corr_cnt=1; RD at 0x150, then WR with be all-ones and wdata = rdata_i; gnt tied 1 → back in IDLE 2 cycles after leaving it.
- Uncorrectable tag error at 0x2A0: uncorr_cnt=1, uncorr_addr_o=0x2A0, irq_o=1; nothing enqueued and no write; clr_i → counters, irq_o and overflow_o return to 0.
- Six distinct correctable errors with enable_i=0: queue holds 4 and overflow_o=1; raise enable_i → exactly 4 RD/WR pairs, in FIFO order.
- Three consecutive errors on the same index: one queue entry and one scrub; corr_cnt=3.
- SCRUB_PERIOD=8, no errors: scrubs at sets 0, 1, 2 … every 8 cycles; pointer wraps after the last set.
- gnt_i held 0 for 3 cycles in WR: returns to RD, re-reads the set, then writes once granted; reset asserted in RD → req_o=0 immediately.
